// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Program counter owner: fetches instructions over a req/ack bus, forms the
// next PC from pcsel, and halts on a misaligned target or a fetch timeout.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         pcsel,
    input  logic [31:0]        imm,
    input  logic [31:0]        alu_result,
    input  logic               instr_done,
    fetch_unit_if.master       imem,
    output logic               instr_valid,
    output logic [31:0]        instr,
    output logic [6:0]         op,
    output logic [2:0]         func3,
    output logic [6:0]         func7,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               fault,
    output logic [1:0]         fault_cause
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             req;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      pc_next, instr_next, target;
    logic             fault_next;
    logic [1:0]       cause_next;
    logic             unused_bit;

    // jalr targets have bit 0 forced low, so alu_result[0] is never consumed
    assign unused_bit = alu_result[0];

    assign imem.req  = req;
    assign imem.addr = pc;

    assign op       = instr[6:0];
    assign func3    = instr[14:12];
    assign func7    = instr[31:25];
    assign pc_plus4 = pc + 32'd4;

    // Candidate next PC; wraps modulo 2^32
    always_comb begin
        target = pc_plus4;
        unique case (pcsel)
            2'b00: target = pc_plus4;
            2'b01: target = pc + imm;
            2'b10: target = {alu_result[31:1], 1'b0};
            2'b11: target = pc;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pc_next    = pc;
        instr_next = instr;
        fault_next = fault;
        cause_next = fault_cause;
        case (state)
            FETCH: begin
                // req is low only in the first cycle after reset; acks are not honoured then
                if (req) begin
                    if (imem.ack) begin
                        instr_next = imem.rdata;
                        cnt_next   = '0;
                        state_next = VALID;
                    end else if (cnt == CNT_LAST) begin
                        fault_next = 1'b1;
                        cause_next = CAUSE_TIMEOUT;
                        state_next = HALT;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            VALID: begin
                if (instr_done) begin
                    if (target[1:0] != 2'b00) begin
                        fault_next = 1'b1;
                        cause_next = CAUSE_MISALIGN;
                        state_next = HALT;
                    end else begin
                        pc_next    = target;
                        state_next = FETCH;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            cnt         <= '0;
            pc          <= RESET_PC;
            instr       <= NOP;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            req         <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            pc          <= pc_next;
            instr       <= instr_next;
            fault       <= fault_next;
            fault_cause <= cause_next;
            req         <= (state_next == FETCH);
            instr_valid <= (state_next == VALID);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential/branch/jalr PC updates,
// misalignment and timeout faults, reset during a fetch, refetch and hold.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pcsel;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        instr_done;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;
    logic [1:0]  fault_cause;

    int n_checks = 0;
    int n_errors = 0;
    int mem_wait = 0;
    int wait_cnt = 0;
    bit spurious = 1'b0;

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .pcsel      (pcsel),
        .imm        (imm),
        .alu_result (alu_result),
        .instr_done (instr_done),
        .imem       (imem),
        .instr_valid(instr_valid),
        .instr      (instr),
        .op         (op),
        .func3      (func3),
        .func7      (func7),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .fault      (fault),
        .fault_cause(fault_cause)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[24:0], 7'b0110011};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: memory responds combinationally to the current request
    task automatic step();
        logic req_now;
        logic ack_now;
        req_now = imem.req;
        if (spurious) begin
            imem.ack   = 1'b1;
            imem.rdata = 32'hDEAD_BEEF;
        end else if (imem.req && wait_cnt >= mem_wait) begin
            imem.ack   = 1'b1;
            imem.rdata = mem_word(imem.addr);
        end else begin
            imem.ack   = 1'b0;
            imem.rdata = 32'h0;
        end
        ack_now = imem.ack;
        @(posedge clk);
        #1;
        if (rst || !req_now || ack_now) wait_cnt = 0;
        else                            wait_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic advance(input logic [1:0] sel);
        pcsel      = sel;
        instr_done = 1'b1;
        step();
        instr_done = 1'b0;
        pcsel      = 2'b00;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !instr_valid; i++) step();
        check(tag, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        int req_cycles;
        logic [31:0] held;
        rst = 1'b1; pcsel = 2'b00; imm = 32'h0; alu_result = 32'h0; instr_done = 1'b0;
        imem.ack = 1'b0; imem.rdata = 32'h0;

        // Reset values
        do_reset();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_req", 32'(imem.req), 32'd0);
        check("rst_fault", {30'd0, fault_cause} | 32'(fault), 32'd0);

        // Zero-wait first fetch
        step();
        check("c1_req", 32'(imem.req), 32'd1);
        check("c1_addr", imem.addr, 32'h0);
        step();
        check("c2_valid", 32'(instr_valid), 32'd1);
        check("c2_op", 32'(op), 32'h13);
        check("c2_func3", 32'(func3), 32'd0);
        check("c2_instr", instr, 32'h0050_0093);
        check("c2_pc4", pc_plus4, 32'h4);

        // Sequential and negative branch
        advance(2'b00);
        check("seq_addr", imem.addr, 32'h4);
        check("seq_notvalid", 32'(instr_valid), 32'd0);
        wait_valid("seq_valid");
        check("seq_instr", instr, mem_word(32'h4));
        advance(2'b00);
        wait_valid("seq2_valid");
        check("seq2_pc", pc, 32'h8);
        imm = 32'hFFFF_FFF8;
        advance(2'b01);
        check("br_addr", imem.addr, 32'h0);
        wait_valid("br_valid");

        // jalr aligned then misaligned
        alu_result = 32'h0000_0105;
        advance(2'b10);
        check("jalr_addr", imem.addr, 32'h104);
        wait_valid("jalr_valid");
        alu_result = 32'h0000_0106;
        advance(2'b10);
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_cause", 32'(fault_cause), 32'd1);
        check("mis_pc", pc, 32'h104);
        step(); step();
        check("mis_req", 32'(imem.req), 32'd0);
        check("mis_valid", 32'(instr_valid), 32'd0);
        check("halt_pc", pc, 32'h104);

        // Memory never acks
        mem_wait = 1000;
        do_reset();
        check("to_rst_fault", 32'(fault), 32'd0);
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (imem.req) req_cycles++;
        end
        check("to_req_cycles", 32'(req_cycles), 32'd16);
        check("to_fault", 32'(fault), 32'd1);
        check("to_cause", 32'(fault_cause), 32'd2);

        // Ack in the last permitted cycle wins
        mem_wait = 15;
        do_reset();
        for (int i = 0; i < 16; i++) step();
        check("late_req", 32'(imem.req), 32'd1);
        step();
        check("late_valid", 32'(instr_valid), 32'd1);
        check("late_fault", 32'(fault), 32'd0);
        check("late_instr", instr, 32'h0050_0093);

        // Reset during a 3-cycle-wait fetch
        mem_wait = 3;
        advance(2'b00);
        check("mid_addr", imem.addr, 32'h4);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_pc", pc, 32'h0);
        check("mid_instr", instr, 32'h0000_0013);
        check("mid_valid", 32'(instr_valid), 32'd0);
        wait_valid("mid_refetch_valid");
        check("mid_refetch_instr", instr, 32'h0050_0093);
        check("mid_refetch_pc", pc, 32'h0);

        // Jump to 0x40, refetch there, then hold with a stray ack
        mem_wait = 0;
        imm = 32'h0000_0040;
        advance(2'b01);
        wait_valid("j40_valid");
        advance(2'b11);
        check("refetch_addr", imem.addr, 32'h40);
        check("refetch_req", 32'(imem.req), 32'd1);
        wait_valid("refetch_valid");
        held = instr;
        check("refetch_instr", held, mem_word(32'h40));
        spurious = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_req", 32'(imem.req), 32'd0);
            check("hold_instr", instr, mem_word(32'h40));
            check("hold_pc", pc, 32'h40);
        end
        spurious = 1'b0;
        check("hold_pc4", pc_plus4, 32'h44);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
